floating_point_addition: RTL and testbench

Single-precision IEEE-754 adder with one registered output stage. It adds two binary32 operands with round-to-nearest-even and handles zero, infinity and NaN, producing one new result per clock. It sits in the arithmetic datapath as a drop-in pipelined replacement for a combinational FP adder.

---
 rtl/fp_add_pkg.sv | 15 +
 rtl/fp_lzc24.sv | 11 +
 rtl/floating_point_addition.sv | 81 ++++++++
 tb/tb_floating_point_addition.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: binary32 field widths, special encodings and the unpacked operand view
package fp_add_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;
endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: leading-zero count of the 27-bit {mantissa, G, R, S} sum; 27 means all zero
module fp_lzc24 (
  input  logic [26:0] x,
  output logic [4:0]  cnt
);
  // highest set bit wins, so scan upward and keep the last hit
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) if (x[i]) cnt = 5'(26 - i);
  end
endmodule

// File: rtl/floating_point_addition.sv
// floating_point_addition: registered binary32 adder, round-to-nearest-even; FPADD_DENORM_EN enables subnormals, otherwise flush-to-zero
module floating_point_addition
  import fp_add_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fnum1,
  input  logic [31:0] fnum2,
  output logic [31:0] fout
);
  fp_t a, b, big, sml;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge, sub, up, uf;
  logic [23:0] m_big, m_sml;
  logic [7:0] e_big, e_sml, d;
  logic [4:0] d_c, lz, sa;
  logic [49:0] sh;
  logic [26:0] aligned, nm;
  logic [27:0] sum;
  logic [24:0] mr;
  logic [9:0] ne, ef;
  logic [31:0] nxt;
  assign a = fnum1;
  assign b = fnum2;
  assign a_nan = a.exp == 8'hFF && a.frac != '0;
  assign b_nan = b.exp == 8'hFF && b.frac != '0;
  assign a_inf = a.exp == 8'hFF && a.frac == '0;
  assign b_inf = b.exp == 8'hFF && b.frac == '0;
`ifdef FPADD_DENORM_EN
  assign a_zero = a.exp == '0 && a.frac == '0;
  assign b_zero = b.exp == '0 && b.frac == '0;
`else
  assign a_zero = a.exp == '0;
  assign b_zero = b.exp == '0;
`endif
  assign a_ge = {a.exp, a.frac} >= {b.exp, b.frac};
  assign big = a_ge ? a : b;
  assign sml = a_ge ? b : a;
  assign m_big = {big.exp != '0, big.frac};
  assign m_sml = {sml.exp != '0, sml.frac};
  assign e_big = big.exp == '0 ? 8'd1 : big.exp;
  assign e_sml = sml.exp == '0 ? 8'd1 : sml.exp;
  assign d = e_big - e_sml;
  assign d_c = d > 8'd26 ? 5'd26 : d[4:0];
  assign sh = {m_sml, 26'b0} >> d_c;
  assign aligned = {sh[49:24], |sh[23:0]};
  assign sub = a.sign ^ b.sign;
  assign sum = sub ? {1'b0, m_big, 3'b0} - {1'b0, aligned} : {1'b0, m_big, 3'b0} + {1'b0, aligned};
  fp_lzc24 u_lzc (.x(sum[26:0]), .cnt(lz));
  // normalize, round, range-check, then let specials override in priority order
  always_comb begin
    sa = lz;
`ifdef FPADD_DENORM_EN
    if ({3'b0, lz} >= e_big) sa = 5'(e_big - 8'd1);
    uf = 1'b0;
`endif
    nm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sa;
    ne = sum[27] ? {2'b0, e_big} + 10'd1 : {2'b0, e_big} - {5'b0, sa};
`ifndef FPADD_DENORM_EN
    uf = ne[9] || ne == '0;
`endif
    up = nm[2] & (nm[1] | nm[0] | nm[3]);
    mr = {1'b0, nm[26:3]} + {24'b0, up};
    ef = mr[24] ? ne + 10'd1 : mr[23] ? ne : 10'd0;
    if (a_nan || b_nan) nxt = QNAN;
    else if (a_inf && b_inf && sub) nxt = QNAN;
    else if (a_inf) nxt = fnum1;
    else if (b_inf) nxt = fnum2;
    else if (a_zero && b_zero) nxt = {a.sign & b.sign, 31'b0};
    else if (a_zero) nxt = fnum2;
    else if (b_zero) nxt = fnum1;
    else if (sum == '0) nxt = '0;
    else if (uf) nxt = {big.sign, 31'b0};
    else if (!ef[9] && ef >= 10'(EXP_MAX)) nxt = big.sign ? NEG_INF : POS_INF;
    else nxt = {big.sign, ef[7:0], mr[24] ? mr[23:1] : mr[22:0]};
  end
  // single output register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fout <= '0;
    else fout <= nxt;
  end
endmodule

// File: tb/tb_floating_point_addition.sv
// tb_floating_point_addition: random and directed binary32 adds checked against an exact-integer reference model
module tb_floating_point_addition;
`ifdef FPADD_DENORM_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [31:0] fnum1, fnum2, fout, exp_r;
  logic vld;
  int n_checks = 0;
  int n_errors = 0;

  floating_point_addition dut (.clk(clk), .rst(rst), .fnum1(fnum1), .fnum2(fnum2), .fout(fout));

  always #5 clk = ~clk;

  // exact sum as a scaled integer, then a single RNE rounding to binary32
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn, xi, yi, xz, yz, s_hi, s_lo, s;
    longint m_hi, m_lo, v, mag, q, rem, half;
    int e_hi, e_lo, d, p, t, sh;
    xn = x[30:23] == 8'hFF && x[22:0] != 0;
    yn = y[30:23] == 8'hFF && y[22:0] != 0;
    xi = x[30:23] == 8'hFF && x[22:0] == 0;
    yi = y[30:23] == 8'hFF && y[22:0] == 0;
    xz = x[30:23] == 0 && (x[22:0] == 0 || !DEN);
    yz = y[30:23] == 0 && (y[22:0] == 0 || !DEN);
    if (xn || yn) return 32'h7FC0_0000;
    if (xi && yi && x[31] != y[31]) return 32'h7FC0_0000;
    if (xi) return x;
    if (yi) return y;
    if (xz && yz) return {x[31] & y[31], 31'b0};
    if (xz) return y;
    if (yz) return x;
    e_hi = (x[30:23] == 0 ? 1 : int'(x[30:23])) - 150;
    e_lo = (y[30:23] == 0 ? 1 : int'(y[30:23])) - 150;
    m_hi = {40'b0, x[30:23] != 0, x[22:0]};
    m_lo = {40'b0, y[30:23] != 0, y[22:0]};
    s_hi = x[31];
    s_lo = y[31];
    if (e_lo > e_hi) begin
      {e_hi, e_lo} = {e_lo, e_hi};
      {m_hi, m_lo} = {m_lo, m_hi};
      {s_hi, s_lo} = {s_lo, s_hi};
    end
    d = e_hi - e_lo;
    if (d > 38) begin
      m_lo = 64'sd1;
      d = 38;
      e_lo = e_hi - 38;
    end
    v = m_hi << d;
    if (s_hi) v = -v;
    v += s_lo ? -m_lo : m_lo;
    if (v == 0) return 32'h0;
    s = v < 0;
    mag = s ? -v : v;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (!DEN && e_lo + p + 127 <= 0) return {s, 31'b0};
    t = e_lo + p - 23;
    if (DEN && t < -149) t = -149;
    sh = t - e_lo;
    if (sh <= 0) q = mag << -sh;
    else begin
      q = mag >> sh;
      rem = mag & ((64'sd1 << sh) - 64'sd1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == (64'sd1 << 24)) begin
      q = q >> 1;
      t++;
    end
    if (q < (64'sd1 << 23)) return {s, 8'h00, q[22:0]};
    if (t + 150 >= 255) return {s, 8'hFF, 23'b0};
    return {s, 8'(t + 150), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] r);
    logic [31:0] v;
    int e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v = {~r[31], r[30:0]};
      3: v[30:23] = 8'($urandom_range(250, 254));
      8: v = {~r[31], r[30:2], v[1:0]};
      4, 5, 6, 7: begin
        e = int'(r[30:23]) + int'($urandom_range(0, 60)) - 30;
        v[30:23] = 8'(e < 1 ? 1 : e > 254 ? 254 : e);
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  task automatic lit(input string n, input logic [31:0] x, input logic [31:0] y, input logic [31:0] w);
    @(negedge clk);
    fnum1 = x;
    fnum2 = y;
    @(posedge clk);
    #1;
    check({n, "_dut"}, fout, w);
    check({n, "_model"}, model(x, y), w);
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      exp_r <= '0;
      vld <= 1'b0;
    end else begin
      exp_r <= model(fnum1, fnum2);
      vld <= 1'b1;
    end

  always @(negedge clk)
    if (rst) check("rst_hold", fout, 32'h0);
    else if (vld) check("stream", fout, exp_r);

  initial begin
    rst = 1'b1;
    fnum1 = '0;
    fnum2 = '0;
    repeat (2) @(negedge clk);
    check("reset", fout, 32'h0);
    rst = 1'b0;
    lit("add_7p4", 32'h404CCCCC, 32'h40866666, 32'h40ECCCCC);
    lit("add_1p17", 32'h3F28F5C2, 32'h3F028F5C, 32'h3F95C28F);
    lit("add_m6p9", 32'hBF000000, 32'hC0CCCCCC, 32'hC0DCCCCC);
    lit("mixed_5p9", 32'hBF000000, 32'h40CCCCCC, 32'h40BCCCCC);
    lit("rne_tie", 32'h4034B4B5, 32'hBF70F0F1, 32'h3FF0F0F2);
    lit("cancel", 32'h40490FDB, 32'hC0490FDB, 32'h00000000);
    lit("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    lit("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    lit("nan_a", 32'h7FC12345, 32'h3F800000, 32'h7FC00000);
    lit("nan_b", 32'hFF800000, 32'hFF800001, 32'h7FC00000);
    lit("inf_fin", 32'h42000000, 32'hFF800000, 32'hFF800000);
    lit("zero_x", 32'h80000000, 32'hC0490FDB, 32'hC0490FDB);
    lit("pz_nz", 32'h00000000, 32'h80000000, 32'h00000000);
    lit("nz_nz", 32'h80000000, 32'h80000000, 32'h80000000);
    lit("denorm", 32'h00000001, 32'h00000001, DEN ? 32'h00000002 : 32'h00000000);
    @(negedge clk);
    fnum1 = 32'h3F800000;
    fnum2 = 32'h40000000;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", fout, 32'h0);
    @(negedge clk);
    fnum1 = 32'h3F800000;
    fnum2 = 32'h3F800000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", fout, 32'h40000000);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      fnum1 = rnd_op(fnum2);
      fnum2 = rnd_op(fnum1);
    end
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
